// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for an 800x600 @ 72 Hz display path.
//
// Counts pixels and lines and exports the live count as PixelX/PixelY so the
// renderer can look up colour. The renderer's registered colour returns on
// R_in/G_in/B_in PIPE_DELAY clocks later. Visibility and both syncs are delayed
// by the same amount, then one output register blanks the colour and drives
// the connector.
//
// Ports:
//   clk, reset_n            pixel clock, asynchronous active-low reset
//   PixelX, PixelY          live horizontal / vertical count (no added latency)
//   R_in, G_in, B_in        renderer colour, PIPE_DELAY clocks behind the count
//   vga_r, vga_g, vga_b     blanked colour to the DAC
//   hsync, vsync            syncs aligned with the colour outputs
//   frame_start             1-clock strobe, the cycle after count (0,0)
//   vblank_start            1-clock strobe, the cycle after count (0,V_VISIBLE)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned H_FRONT    = 56,
  parameter int unsigned H_SYNC     = 120,
  parameter int unsigned H_BACK     = 64,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned V_FRONT    = 37,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BACK     = 23,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [10:0] PixelX,
  output logic [10:0] PixelY,
  input  logic [2:0]  R_in,
  input  logic [2:0]  G_in,
  input  logic [1:0]  B_in,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        vblank_start
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Both counters are 11 bits wide; the renderer interface only carries 3 bits
  // of latency headroom in practice.
  if (HTotal > 2047 || VTotal > 2047) begin : g_bad_totals
    $error("vga_timing_gen: timing totals exceed 11-bit counter range");
  end
  if (PIPE_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..4");
  end

  localparam logic [10:0] HVis       = 11'(H_VISIBLE);
  localparam logic [10:0] HSyncStart = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HSyncEnd   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] HLast      = 11'(HTotal - 1);
  localparam logic [10:0] VVis       = 11'(V_VISIBLE);
  localparam logic [10:0] VSyncStart = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VSyncEnd   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] VLast      = 11'(VTotal - 1);

  localparam logic       SyncIdle = ~SYNC_POL;
  // Pipeline word is {vsync level, hsync level, visible}.
  localparam logic [2:0] PipeRst  = {SyncIdle, SyncIdle, 1'b0};

  // ---------------------------------------------------------------------------
  // Pixel / line counters
  // ---------------------------------------------------------------------------
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        h_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == HLast);
    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VLast) ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= 11'd0;
      v_cnt_q <= 11'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign PixelX = h_cnt_q;
  assign PixelY = v_cnt_q;

  // ---------------------------------------------------------------------------
  // Raw decodes from the live count. Syncs are carried as output levels so the
  // pipeline reset value is simply the idle level.
  // ---------------------------------------------------------------------------
  logic       vis_raw, hs_win, vs_win;
  logic [2:0] raw;
  logic [2:0] dly;

  always_comb begin
    vis_raw = (h_cnt_q < HVis) && (v_cnt_q < VVis);
    hs_win  = (h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd);
    vs_win  = (v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd);
    raw     = {vs_win ? SYNC_POL : SyncIdle, hs_win ? SYNC_POL : SyncIdle, vis_raw};
  end

  // ---------------------------------------------------------------------------
  // Alignment delay matching the renderer's colour latency
  // ---------------------------------------------------------------------------
  if (PIPE_DELAY == 0) begin : g_no_pipe
    assign dly = raw;
  end else begin : g_pipe
    logic [2:0] pipe_q [PIPE_DELAY];
    logic [2:0] pipe_d [PIPE_DELAY];

    always_comb begin
      pipe_d[0] = raw;
      for (int i = 1; i < int'(PIPE_DELAY); i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(PIPE_DELAY); i++) begin
          pipe_q[i] <= PipeRst;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign dly = pipe_q[PIPE_DELAY-1];
  end

  // ---------------------------------------------------------------------------
  // Output register: blanking and sync drive, plus frame-rate strobes
  // ---------------------------------------------------------------------------
  logic [2:0] vga_r_q, vga_r_d;
  logic [2:0] vga_g_q, vga_g_d;
  logic [1:0] vga_b_q, vga_b_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_start_q, frame_start_d;
  logic       vblank_start_q, vblank_start_d;

  always_comb begin
    // Renderer colour is discarded outside the visible area (border colour etc.).
    vga_r_d        = dly[0] ? R_in : 3'd0;
    vga_g_d        = dly[0] ? G_in : 3'd0;
    vga_b_d        = dly[0] ? B_in : 2'd0;
    hsync_d        = dly[1];
    vsync_d        = dly[2];
    frame_start_d  = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    vblank_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == VVis);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r_q        <= 3'd0;
      vga_g_q        <= 3'd0;
      vga_b_q        <= 2'd0;
      hsync_q        <= SyncIdle;
      vsync_q        <= SyncIdle;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      vga_r_q        <= vga_r_d;
      vga_g_q        <= vga_g_d;
      vga_b_q        <= vga_b_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign vga_r        = vga_r_q;
  assign vga_g        = vga_g_q;
  assign vga_b        = vga_b_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule
